// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, branch predictor index and branch tracking entry.
// Pure type/constant package, no logic.
// Imported by the branch resolve unit and its tracking FIFO.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Index into the 8-entry branch predictor.
  typedef logic [2:0] bp_index_t;

  // One in-flight predicted branch, captured at decode.
  typedef struct packed {
    bp_index_t index;
    logic      predict;
    word_t     target;
    word_t     npc;
  } bp_entry_t;

  // Default number of unresolved branches allowed in flight.
  localparam int BP_DEPTH = 4;

endpackage

// File: rtl/bp_track_fifo.sv
// Circular FIFO of in-flight branch entries with combinational head read.
// Latency: entry visible at head the cycle after push; full is combinational on count.
// Backpressure: push ignored when full unless a pop happens in the same cycle; flush wins over push.
module bp_track_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  bp_entry_t push_dat_i,
  input  logic      pop_i,
  input  logic      flush_i,
  output logic      full_o,
  output logic      empty_o,
  output bp_entry_t head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  bp_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_i & ~flush_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  // Next pointers and count; a flush parks the write pointer on the new read pointer.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_dat_i;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves in-flight predicted branches against EX outcome; drives predictor update and fetch redirect.
// Latency: all outputs registered, one cycle after ex_resolve.
// Backpressure: full tells decode to stall its branch; optional stats ports under BP_STATS_EN.
module branch_resolve_unit
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int IDX_W = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             id_push,
  input  logic [IDX_W-1:0] id_index,
  input  logic             id_predict,
  input  logic [31:0]      id_target,
  input  logic [31:0]      id_npc,
  input  logic             ex_resolve,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ext_flush,
  output logic             full,
  output logic             br,
  output logic [IDX_W-1:0] index_update,
  output logic             br_taken,
  output logic [31:0]      br_target_I,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             err_underflow
`ifdef BP_STATS_EN
  ,
  output logic [31:0]      stat_resolved,
  output logic [31:0]      stat_mispred
`endif
);

  bp_entry_t push_dat;
  bp_entry_t head;
  logic      empty;
  logic      res_vld;
  logic      mispredict;
  logic      mis_vld;

  logic             br_q, br_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             taken_q, taken_d;
  logic [31:0]      target_q, target_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      rpc_q, rpc_d;
  logic             err_q, err_d;

  assign push_dat = '{index: bp_index_t'(id_index), predict: id_predict,
                      target: id_target, npc: id_npc};

  bp_track_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .push_i     (id_push),
    .push_dat_i (push_dat),
    .pop_i      (res_vld),
    .flush_i    (ext_flush | mis_vld),
    .full_o     (full),
    .empty_o    (empty),
    .head_o     (head)
  );

  // A resolve only counts when there is a head to compare against.
  assign res_vld    = ex_resolve & ~empty;
  assign mispredict = (head.predict != ex_taken) |
                      (head.predict & ex_taken & (head.target != ex_target));
  assign mis_vld    = res_vld & mispredict;

  // Next values of the update bundle; payload holds between strobes.
  always_comb begin
    br_d       = res_vld;
    index_d    = index_q;
    taken_d    = taken_q;
    target_d   = target_q;
    rpc_d      = rpc_q;
    redirect_d = mis_vld & ~ext_flush;
    err_d      = err_q | (ex_resolve & empty);
    if (res_vld) begin
      index_d  = IDX_W'(head.index);
      taken_d  = ex_taken;
      target_d = ex_target;
      rpc_d    = ex_taken ? ex_target : head.npc;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_q       <= 1'b0;
      index_q    <= '0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      br_q       <= br_d;
      index_q    <= index_d;
      taken_q    <= taken_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
      err_q      <= err_d;
    end
  end

  assign br            = br_q;
  assign index_update  = index_q;
  assign br_taken      = taken_q;
  assign br_target_I   = target_q;
  assign redirect      = redirect_q;
  assign redirect_pc   = rpc_q;
  assign err_underflow = err_q;

`ifdef BP_STATS_EN
  logic [31:0] resolved_q, resolved_d;
  logic [31:0] mispred_q, mispred_d;

  // Saturating counters, bumped alongside the br strobe.
  always_comb begin
    resolved_d = resolved_q;
    mispred_d  = mispred_q;
    if (res_vld && (resolved_q != '1)) begin
      resolved_d = resolved_q + 32'd1;
    end
    if (mis_vld && (mispred_q != '1)) begin
      mispred_d = mispred_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      resolved_q <= '0;
      mispred_q  <= '0;
    end else begin
      resolved_q <= resolved_d;
      mispred_q  <= mispred_d;
    end
  end

  assign stat_resolved = resolved_q;
  assign stat_mispred  = mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: queue-based reference model plus directed literal checks.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        id_push = 1'b0;
  logic [2:0]  id_index = '0;
  logic        id_predict = 1'b0;
  logic [31:0] id_target = '0;
  logic [31:0] id_npc = '0;
  logic        ex_resolve = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ext_flush = 1'b0;
  logic        full, br, br_taken, redirect, err_underflow;
  logic [2:0]  index_update;
  logic [31:0] br_target_I, redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif

  branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .id_push(id_push), .id_index(id_index), .id_predict(id_predict),
    .id_target(id_target), .id_npc(id_npc),
    .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target),
    .ext_flush(ext_flush), .full(full), .br(br), .index_update(index_update),
    .br_taken(br_taken), .br_target_I(br_target_I), .redirect(redirect),
    .redirect_pc(redirect_pc), .err_underflow(err_underflow)
`ifdef BP_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  idx;
    logic        pr;
    logic [31:0] tg;
    logic [31:0] npc;
  } ent_t;

  ent_t        q[$];
  logic        exp_br, exp_tk, exp_redir, exp_err;
  logic [2:0]  exp_idx;
  logic [31:0] exp_tgt, exp_rpc, exp_res_cnt, exp_mis_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q = {};
    exp_br = 0; exp_tk = 0; exp_redir = 0; exp_err = 0; exp_idx = 0;
    exp_tgt = 0; exp_rpc = 0; exp_res_cnt = 0; exp_mis_cnt = 0;
  endtask

  // Reference behaviour for one clock edge, from the current input values.
  task automatic model_step();
    ent_t h;
    logic mis;
    mis = 0;
    exp_br = 0;
    exp_redir = 0;
    if (ex_resolve && q.size() == 0) exp_err = 1;
    if (ex_resolve && q.size() > 0) begin
      h = q.pop_front();
      mis = (h.pr != ex_taken) || (h.pr && ex_taken && h.tg != ex_target);
      exp_br = 1;
      exp_idx = h.idx;
      exp_tk = ex_taken;
      exp_tgt = ex_target;
      exp_rpc = ex_taken ? ex_target : h.npc;
      exp_redir = mis && !ext_flush;
      if (exp_res_cnt != 32'hffff_ffff) exp_res_cnt++;
      if (mis && exp_mis_cnt != 32'hffff_ffff) exp_mis_cnt++;
    end
    if (ext_flush || mis) q = {};
    else if (id_push && q.size() < DEPTH) q.push_back('{id_index, id_predict, id_target, id_npc});
  endtask

  task automatic compare_all();
    cmp("br", br, exp_br);
    cmp("redirect", redirect, exp_redir);
    cmp("err_underflow", err_underflow, exp_err);
    cmp("full", full, q.size() == DEPTH);
    if (exp_br) begin
      cmp("index_update", index_update, exp_idx);
      cmp("br_taken", br_taken, exp_tk);
      cmp("br_target_I", br_target_I, exp_tgt);
    end
    if (exp_redir) cmp("redirect_pc", redirect_pc, exp_rpc);
`ifdef BP_STATS_EN
    cmp("stat_resolved", stat_resolved, exp_res_cnt);
    cmp("stat_mispred", stat_mispred, exp_mis_cnt);
`endif
  endtask

  // Called just after a falling edge: drive, clock, then check at the next falling edge.
  task automatic step(input logic p, input logic [2:0] idx, input logic pr,
                      input logic [31:0] tg, input logic [31:0] npc,
                      input logic r, input logic tk, input logic [31:0] tt,
                      input logic fl);
    id_push = p; id_index = idx; id_predict = pr; id_target = tg; id_npc = npc;
    ex_resolve = r; ex_taken = tk; ex_target = tt; ext_flush = fl;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic push(input logic [2:0] idx, input logic pr, input logic [31:0] tg,
                      input logic [31:0] npc);
    step(1, idx, pr, tg, npc, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tt);
    step(0, 0, 0, 0, 0, 1, tk, tt, 0);
  endtask

  initial begin
    logic        p, r, fl, tk, pr;
    logic [31:0] tt, tg;
    logic [31:0] tgts [3];
    tgts[0] = 32'h100; tgts[1] = 32'h104; tgts[2] = 32'h200;

    model_reset();
    #3;
    compare_all();
    cmp("rst_full", full, 0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // Correct taken prediction.
    push(3, 1, 32'h100, 32'h44);
    resolve(1, 32'h100);
    cmp("t1_br", br, 1);
    cmp("t1_idx", index_update, 3);
    cmp("t1_taken", br_taken, 1);
    cmp("t1_redirect", redirect, 0);

    // Direction mispredict.
    push(5, 0, 32'h0, 32'h80);
    resolve(1, 32'h200);
    cmp("t2_redirect", redirect, 1);
    cmp("t2_rpc", redirect_pc, 32'h200);
    cmp("t2_tgt", br_target_I, 32'h200);

    // Target mispredict.
    push(1, 1, 32'h300, 32'h10);
    resolve(1, 32'h304);
    cmp("t3_redirect", redirect, 1);
    cmp("t3_rpc", redirect_pc, 32'h304);

    // Fill, overflow push, push with pop while full, then drain in order.
    for (int i = 0; i < 4; i++) push(3'(i), 0, 32'h0, 32'h1000 + 32'(i));
    cmp("t4_full", full, 1);
    push(7, 0, 32'h0, 32'h2000);
    cmp("t4_full_after_extra", full, 1);
    step(1, 6, 0, 32'h0, 32'h3000, 1, 0, 32'h0, 0);
    cmp("t4_pushpop_idx", index_update, 0);
    cmp("t4_still_full", full, 1);
    resolve(0, 0); cmp("t4_order1", index_update, 1);
    resolve(0, 0); cmp("t4_order2", index_update, 2);
    resolve(0, 0); cmp("t4_order3", index_update, 3);
    resolve(0, 0); cmp("t4_order4", index_update, 6);
    cmp("t4_drained", full, 0);

    // Mispredict on head with two queued and a push: queue empties.
    push(1, 0, 32'h0, 32'h40); push(2, 0, 32'h0, 32'h48); push(3, 0, 32'h0, 32'h4c);
    step(1, 7, 0, 32'h0, 32'h50, 1, 1, 32'h500, 0);
    cmp("t5_redirect", redirect, 1);
    cmp("t5_rpc", redirect_pc, 32'h500);
    resolve(0, 0);
    cmp("t5_underflow", err_underflow, 1);
    cmp("t5_no_br", br, 0);

    // External flush with three queued plus a push.
    push(5, 0, 32'h0, 32'h60); push(6, 0, 32'h0, 32'h64); push(7, 0, 32'h0, 32'h68);
    step(1, 1, 0, 32'h0, 32'h6c, 0, 0, 32'h0, 1);
    cmp("t6_redirect", redirect, 0);
    cmp("t6_full", full, 0);
    push(4, 0, 32'h0, 32'h70);
    resolve(0, 0);
    cmp("t6_fresh_head", index_update, 4);

    // Flush with a mispredicting resolve: update issues, redirect suppressed.
    push(2, 1, 32'h100, 32'h74);
    step(0, 0, 0, 0, 0, 1, 0, 32'h0, 1);
    cmp("t7_br", br, 1);
    cmp("t7_redirect", redirect, 0);

    // Reset while a pulse is live.
    push(1, 0, 32'h0, 32'h80);
    push(2, 0, 32'h0, 32'h84);
    id_push = 0; ex_resolve = 1; ex_taken = 1; ex_target = 32'h900; ext_flush = 0;
    @(posedge CLK);
    #1;
    cmp("t8_pre_redirect", redirect, 1);
    nRST = 1'b0;
    #1;
    model_reset();
    cmp("t8_br", br, 0);
    cmp("t8_redirect", redirect, 0);
    cmp("t8_rpc", redirect_pc, 0);
    cmp("t8_err", err_underflow, 0);
    compare_all();
    ex_resolve = 0;
    @(negedge CLK);
    nRST = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      p  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 40);
      fl = ($urandom_range(0, 99) < 4);
      pr = $urandom_range(0, 1);
      tg = tgts[$urandom_range(0, 2)];
      tk = $urandom_range(0, 1);
      tt = tgts[$urandom_range(0, 2)];
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        tk = q[0].pr;
        if (q[0].pr) tt = q[0].tg;
      end
      step(p, 3'($urandom_range(0, 7)), pr, tg, $urandom, r, tk, tt, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
